fifo_rr_mux: RTL and testbench

Multi-channel buffered multiplexer: NUM_CH independent parametrised FIFOs feed a round-robin arbiter and a single registered valid/ready output port. It is the next-generation combination of the 4:1 byte mux and the single-channel FIFO. It sits where several producers share one consumer. It adds simultaneous read/write per channel, correct full detection, per-channel occupancy and overflow reporting, and output backpressure.

---
 rtl/fifo_rr_mux.sv | 131 +++++++++++++
 tb/tb_fifo_rr_mux.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_mux.sv
// NUM_CH independent FIFOs drained by a round-robin arbiter into one registered valid/ready output.
// Grant and pop depend only on registered empty/out_valid and live out_ready; write data never reaches an output combinationally.
module fifo_rr_mux #(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  localparam int CW  = $clog2(DEPTH) + 1,
  localparam int PW  = $clog2(DEPTH),
  localparam int CHW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            write,
  input  logic [NUM_CH*DATA_WIDTH-1:0] DATA_IN,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH*CW-1:0]         count,
  output logic [NUM_CH-1:0]            overflow,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        DATA_OUT,
  output logic [CHW-1:0]               out_channel
);

  logic [DATA_WIDTH-1:0]             mem_q [NUM_CH][DEPTH];
  logic [NUM_CH-1:0][PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [NUM_CH-1:0][CW-1:0]         count_q, count_d;
  logic [NUM_CH-1:0]                 full_q, full_d, empty_q, empty_d, overflow_q;
  logic                              out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]             data_q, data_d;
  logic [CHW-1:0]                    chan_q, chan_d, last_grant_q, last_grant_d, grant;
  logic                              load, found;
  logic [NUM_CH-1:0]                 wr_acc, pop;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] din;

  assign din = DATA_IN;

  // Full is the registered flag, so a pop in the same cycle never frees room for a write.
  assign wr_acc = write & ~full_q;

  function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CHW'(s);
  endfunction

  always_comb begin
    load  = !out_valid_q || out_ready;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!found && !empty_q[rr_idx(last_grant_q, k)]) begin
        found = 1'b1;
        grant = rr_idx(last_grant_q, k);
      end
    end
    pop = '0;
    if (load && found) pop[grant] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    full_d  = '0;
    empty_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_acc[i] && !pop[i])      count_d[i] = count_q[i] + CW'(1);
      else if (pop[i] && !wr_acc[i]) count_d[i] = count_q[i] - CW'(1);
      full_d[i]  = (count_d[i] == CW'(DEPTH));
      empty_d[i] = (count_d[i] == '0);
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    data_d       = data_q;
    chan_d       = chan_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        data_d       = mem_q[grant][rd_ptr_q[grant]];
        chan_d       = grant;
        last_grant_d = grant;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= '0;
      empty_q      <= '1;
      overflow_q   <= '0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      chan_q       <= '0;
      last_grant_q <= CHW'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_acc[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop[i])    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
      end
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_q | (write & full_q);
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      chan_q       <= chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_acc[i]) mem_q[i][wr_ptr_q[i]] <= din[i];
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign out_valid   = out_valid_q;
  assign DATA_OUT    = data_q;
  assign out_channel = chan_q;

endmodule

// File: tb/tb_fifo_rr_mux.sv
// Bench for fifo_rr_mux: queue-based reference model plus per-channel scoreboard checked by a negedge monitor.
module tb_fifo_rr_mux;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int DW     = 8;
  localparam int CW     = 4;
  localparam int CHW    = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      write;
  logic [NUM_CH*DW-1:0]   DATA_IN;
  logic                   out_ready;
  logic [NUM_CH-1:0]      full, empty, overflow;
  logic [NUM_CH*CW-1:0]   count;
  logic                   out_valid;
  logic [DW-1:0]          DATA_OUT;
  logic [CHW-1:0]         out_channel;

  fifo_rr_mux #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .write(write), .DATA_IN(DATA_IN),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready), .DATA_OUT(DATA_OUT),
    .out_channel(out_channel)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [DW-1:0] word_q_t[$];
  word_q_t           mq[NUM_CH];
  word_q_t           exp_q[NUM_CH];
  logic              m_vld;
  logic [DW-1:0]     m_dat;
  int                m_ch, m_last;
  logic [NUM_CH-1:0] m_ovf;
  int                log_ch[$];
  int                log_dat[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      mq[i].delete();
      exp_q[i].delete();
    end
    m_vld = 1'b0; m_dat = '0; m_ch = 0; m_last = NUM_CH - 1; m_ovf = '0;
    log_ch.delete();
    log_dat.delete();
  endtask

  function automatic bit model_idle();
    bit idle;
    idle = !m_vld;
    for (int i = 0; i < NUM_CH; i++) if (mq[i].size() != 0) idle = 0;
    return idle;
  endfunction

  // One clock edge of the reference: arbitration over the queues, then writes judged on pre-edge occupancy.
  task automatic model_step();
    logic [NUM_CH-1:0] was_full;
    bit found;
    int g;
    for (int i = 0; i < NUM_CH; i++) was_full[i] = (mq[i].size() == DEPTH);
    found = 0;
    g = 0;
    if (!m_vld || out_ready) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (m_last + k) % NUM_CH;
        if (!found && mq[c].size() > 0) begin found = 1; g = c; end
      end
      m_vld = found;
      if (found) begin
        m_dat  = mq[g].pop_front();
        m_ch   = g;
        m_last = g;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (write[i]) begin
        if (was_full[i]) m_ovf[i] = 1'b1;
        else begin
          mq[i].push_back(DATA_IN[i*DW +: DW]);
          exp_q[i].push_back(DATA_IN[i*DW +: DW]);
        end
      end
    end
  endtask

  always @(posedge clock) if (!reset) model_step();

  logic              stalled = 1'b0;
  logic [DW-1:0]     hold_dat;
  logic [CHW-1:0]    hold_ch;
  logic [38:0]       ev, av;
  logic [NUM_CH*CW-1:0] ecnt;
  logic [NUM_CH-1:0] efull, eempty;
  int                mon_ch;

  always @(negedge clock) begin
    if (reset) stalled = 1'b0;
    else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ecnt[i*CW +: CW] = CW'(mq[i].size());
        efull[i]  = (mq[i].size() == DEPTH);
        eempty[i] = (mq[i].size() == 0);
      end
      ev = {m_vld, m_dat, CHW'(m_ch), ecnt, efull, eempty, m_ovf};
      av = {out_valid, DATA_OUT, out_channel, count, full, empty, overflow};
      chk("state", 64'(av), 64'(ev));
      if (stalled) chk("stall_hold", 64'({out_channel, DATA_OUT}), 64'({hold_ch, hold_dat}));
      if (out_valid && out_ready) begin
        mon_ch = int'(out_channel);
        chk("xfer_avail", 64'(exp_q[mon_ch].size() > 0), 64'd1);
        if (exp_q[mon_ch].size() > 0) chk("xfer_data", 64'(DATA_OUT), 64'(exp_q[mon_ch].pop_front()));
        log_ch.push_back(mon_ch);
        log_dat.push_back(int'(DATA_OUT));
      end
      stalled  = out_valid && !out_ready;
      hold_dat = DATA_OUT;
      hold_ch  = out_channel;
    end
  end

  task automatic step(input logic [NUM_CH-1:0] wr, input logic [NUM_CH*DW-1:0] din, input logic rdy);
    write = wr; DATA_IN = din; out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    write = '0; DATA_IN = '0; out_ready = 1'b0;
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(DATA_OUT), 64'd0);
    chk("rst_out_channel", 64'(out_channel), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'hF);
    chk("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clock);
    #3 reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 200 && !model_idle()) begin
      step('0, '0, 1'b1);
      n++;
    end
    chk("drain_done", 64'(model_idle()), 64'd1);
  endtask

  initial begin
    int tot;
    reset = 1'b0; write = '0; DATA_IN = '0; out_ready = 1'b0;
    model_clear();
    do_reset();

    step(4'b0100, 32'hA5 << 16, 1'b1);
    chk("lat_count2", 64'(count[2*CW +: CW]), 64'd1);
    chk("lat_valid_t", 64'(out_valid), 64'd0);
    step('0, '0, 1'b1);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(DATA_OUT), 64'hA5);
    chk("lat_chan", 64'(out_channel), 64'd2);
    step('0, '0, 1'b1);
    chk("lat_done", 64'(out_valid), 64'd0);

    for (int v = 0; v < 10; v++) step(4'b0001, 32'(v), 1'b0);
    chk("ovf_count0", 64'(count[0 +: CW]), 64'd8);
    chk("ovf_full0", 64'(full[0]), 64'd1);
    chk("ovf_flag0", 64'(overflow[0]), 64'd1);
    chk("ovf_head", 64'({out_valid, DATA_OUT}), 64'h100);
    log_ch.delete(); log_dat.delete();
    drain();
    chk("ovf_drain_len", 64'(log_dat.size()), 64'd9);
    for (int i = 0; i < 9 && i < log_dat.size(); i++) chk("ovf_drain_data", 64'(log_dat[i]), 64'(i));
    chk("ovf_empty0", 64'(empty[0]), 64'd1);

    for (int n = 0; n < 8; n++) step(4'($urandom), $urandom, 1'($urandom));
    do_reset();

    step(4'hF, 32'h40302010, 1'b0);
    step(4'hF, 32'h41312111, 1'b0);
    log_ch.delete(); log_dat.delete();
    repeat (10) step('0, '0, 1'b1);
    chk("rr_len", 64'(log_ch.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_ch.size(); i++) begin
      chk("rr_chan", 64'(log_ch[i]), 64'(i % 4));
      chk("rr_data", 64'(log_dat[i]), 64'(16 * (i % 4 + 1) + i / 4));
    end

    for (int n = 0; n < 40; n++) step(4'b1010, $urandom, 1'(n % 2));
    drain();

    for (int n = 0; n < 300; n++) step(4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    drain();

    do_reset();
    for (int n = 0; n < 9; n++) step(4'b0010, 32'(n + 1) << 8, 1'b0);
    chk("fp_count_full", 64'(count[CW +: CW]), 64'd8);
    chk("fp_full1", 64'(full[1]), 64'd1);
    step(4'b0010, 32'h0000EE00, 1'b1);
    chk("fp_ovf1", 64'(overflow[1]), 64'd1);
    chk("fp_count1", 64'(count[CW +: CW]), 64'd7);
    drain();

    tot = 0;
    for (int i = 0; i < NUM_CH; i++) tot += exp_q[i].size();
    chk("sb_all_delivered", 64'(tot), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
